// File: rtl/makestuff_ram_arb.sv
// Round-robin arbiter sharing one single-clock RAM (1 write + 1 registered read port) between NUM_REQ clients.
// Optional same-cycle write-to-read forwarding: define MAKESTUFF_RAM_ARB_FWD_EN.
module makestuff_ram_arb #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_NBITS = 5,
    parameter int DATA_NBITS = 16
) (
    input  logic                           clk_in,
    input  logic                           reset_in,
    input  logic [NUM_REQ-1:0]             wrValid_in,
    input  logic [NUM_REQ*ADDR_NBITS-1:0]  wrAddr_in,
    input  logic [NUM_REQ*DATA_NBITS-1:0]  wrData_in,
    output logic [NUM_REQ-1:0]             wrReady_out,
    input  logic [NUM_REQ-1:0]             rdValid_in,
    input  logic [NUM_REQ*ADDR_NBITS-1:0]  rdAddr_in,
    output logic [NUM_REQ-1:0]             rdReady_out,
    output logic [DATA_NBITS-1:0]          rdData_out,
    output logic [NUM_REQ-1:0]             rdDataValid_out,
    output logic                           ramWrEnable_out,
    output logic [ADDR_NBITS-1:0]          ramWrAddr_out,
    output logic [DATA_NBITS-1:0]          ramWrData_out,
    output logic [ADDR_NBITS-1:0]          ramRdAddr_out,
    input  logic [DATA_NBITS-1:0]          ramRdData_in
);
    localparam int PTR_NBITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_NBITS-1:0] LAST_IDX = PTR_NBITS'(NUM_REQ - 1);

    logic [PTR_NBITS-1:0]  r_wr_ptr;
    logic [PTR_NBITS-1:0]  r_rd_ptr;
    logic [NUM_REQ-1:0]    r_rd_tag;
    logic [ADDR_NBITS-1:0] r_rd_addr;

    logic                  w_wr_found;
    logic                  w_rd_found;
    logic [PTR_NBITS-1:0]  w_wr_win;
    logic [PTR_NBITS-1:0]  w_rd_win;
    logic                  w_wr_grant;
    logic                  w_rd_grant;
    logic [ADDR_NBITS-1:0] w_wr_addr_sel;
    logic [DATA_NBITS-1:0] w_wr_data_sel;
    logic [ADDR_NBITS-1:0] w_rd_addr_sel;

    // First requester at or after ptr, searching upward modulo NUM_REQ; returns {found, index}.
    function automatic logic [PTR_NBITS:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                   input logic [PTR_NBITS-1:0] ptr);
        logic                 found;
        logic [PTR_NBITS-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int c;
            c = (int'(ptr) + k) % NUM_REQ;
            if (!found && valid[c]) begin
                found = 1'b1;
                idx   = PTR_NBITS'(c);
            end
        end
        return {found, idx};
    endfunction

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        wrReady_out = '0;
        rdReady_out = '0;
        {w_wr_found, w_wr_win} = rr_pick(wrValid_in, r_wr_ptr);
        {w_rd_found, w_rd_win} = rr_pick(rdValid_in, r_rd_ptr);
        w_wr_grant = w_wr_found && !reset_in;
        w_rd_grant = w_rd_found && !reset_in;
        if (w_wr_grant) wrReady_out = NUM_REQ'(1) << w_wr_win;
        if (w_rd_grant) rdReady_out = NUM_REQ'(1) << w_rd_win;
        w_wr_addr_sel = wrAddr_in[w_wr_win*ADDR_NBITS +: ADDR_NBITS];
        w_wr_data_sel = wrData_in[w_wr_win*DATA_NBITS +: DATA_NBITS];
        w_rd_addr_sel = rdAddr_in[w_rd_win*ADDR_NBITS +: ADDR_NBITS];
    end

    assign ramWrEnable_out = w_wr_grant;
    assign ramWrAddr_out   = w_wr_grant ? w_wr_addr_sel : '0;
    assign ramWrData_out   = w_wr_grant ? w_wr_data_sel : '0;
    // Read address parks on the last granted address so the RAM output stays stable when idle.
    assign ramRdAddr_out   = w_rd_grant ? w_rd_addr_sel : r_rd_addr;
    assign rdDataValid_out = r_rd_tag;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rd_tag  <= '0;
            r_rd_addr <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            r_rd_tag <= rdReady_out;
            if (w_wr_grant) r_wr_ptr <= (w_wr_win == LAST_IDX) ? '0 : w_wr_win + 1'b1;
            if (w_rd_grant) begin
                r_rd_ptr  <= (w_rd_win == LAST_IDX) ? '0 : w_rd_win + 1'b1;
                r_rd_addr <= w_rd_addr_sel;
            end
        end
    end

`ifdef MAKESTUFF_RAM_ARB_FWD_EN
    logic                  r_fwd;
    logic [DATA_NBITS-1:0] r_fwd_data;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_fwd      <= 1'b0;
            r_fwd_data <= '0;
        end else begin
            r_fwd      <= w_wr_grant && w_rd_grant && (w_wr_addr_sel == w_rd_addr_sel);
            r_fwd_data <= w_wr_data_sel;
        end
    end

    assign rdData_out = r_fwd ? r_fwd_data : ramRdData_in;
`else
    assign rdData_out = ramRdData_in;
`endif

endmodule
